// File: rtl/sr_cmd_driver_pkg.sv
// Shared definitions for the SR command driver.
//   op_e      : command encodings carried on req_op
//   state_e   : driver FSM states
//   TIMER_W   : width of the pulse/gap down-counter
//   op_target : level the element should hold after a given command
package sr_cmd_driver_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10
    } state_e;

    localparam int unsigned TIMER_W = 16;

    function automatic logic op_target(input op_e op, input logic q);
        logic t;
        unique case (op)
            OP_HOLD: t = q;
            OP_CLR:  t = 1'b0;
            OP_SET:  t = 1'b1;
            OP_TGL:  t = ~q;
            default: t = q;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : value loaded; done asserts load_val edges after the load
//   done      : count has reached zero
module sr_pulse_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// Command-side driver for a negedge-sampled SR flip-flop. Accepts level commands over
// valid/ready and turns them into timed, never-overlapping s/r pulses followed by a 00 gap.
// Ports:
//   clk, rst       : clock (posedge), asynchronous active-high reset
//   req_valid/ready: command handshake; ready only in IDLE and out of reset
//   req_op         : 00 hold, 01 clear, 10 set, 11 toggle
//   s, r           : registered drives to the SR element
//   q_shadow       : committed model of the downstream q
//   busy           : high in PULSE or GAP
//   redundant_cnt  : saturating count of filtered non-hold commands
module sr_cmd_driver
    import sr_cmd_driver_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = 1,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter bit          SKIP_REDUNDANT = 1'b1,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    output logic             s,
    output logic             r,
    output logic             q_shadow,
    output logic             busy,
    output logic [CNT_W-1:0] redundant_cnt
);

    if (PULSE_CYCLES == 0) begin : g_bad_pulse_cycles
        $error("sr_cmd_driver: PULSE_CYCLES must be >= 1");
    end

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   =
        (GAP_CYCLES == 0) ? '0 : TIMER_W'(GAP_CYCLES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);

    state_e             state;
    logic               target_q;
    op_e                op;
    logic               accept;
    logic               acc_target;
    logic               no_pulse;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_done;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_comb begin
        op         = op_e'(req_op);
        accept     = req_valid && req_ready;
        acc_target = op_target(op, q_shadow);
        no_pulse   = (op == OP_HOLD) || (SKIP_REDUNDANT && (acc_target == q_shadow));

        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (state == IDLE && accept && !no_pulse) begin
            tmr_load     = 1'b1;
            tmr_load_val = PULSE_LOAD;
        end else if (state == PULSE && tmr_done && HAS_GAP) begin
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
        end
    end

    sr_pulse_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s             <= 1'b0;
            r             <= 1'b0;
            q_shadow      <= 1'b0;
            target_q      <= 1'b0;
            redundant_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (no_pulse) begin
                            if (op != OP_HOLD && redundant_cnt != '1) begin
                                redundant_cnt <= redundant_cnt + CNT_W'(1);
                            end
                        end else begin
                            state    <= PULSE;
                            s        <= acc_target;
                            r        <= ~acc_target;
                            target_q <= acc_target;
                        end
                    end
                end
                PULSE: begin
                    if (tmr_done) begin
                        s        <= 1'b0;
                        r        <= 1'b0;
                        q_shadow <= target_q;
                        state    <= HAS_GAP ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (tmr_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: a default instance (a) and a PULSE=3/GAP=2 instance (b),
// each feeding a behavioural negedge-sampled SR flop.
module tb_sr_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       valid_a, valid_b;
    logic [1:0] op_a, op_b;
    logic       ready_a, ready_b;
    logic       s_a, r_a, s_b, r_b;
    logic       qs_a, qs_b;
    logic       busy_a, busy_b;
    logic [7:0] cnt_a, cnt_b;
    logic       qm_a, qm_b;

    int vectors    = 0;
    int miscompares = 0;
    int sr_viol    = 0;

    always #5 clk = ~clk;

    sr_cmd_driver u_dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .req_valid     (valid_a),
        .req_ready     (ready_a),
        .req_op        (op_a),
        .s             (s_a),
        .r             (r_a),
        .q_shadow      (qs_a),
        .busy          (busy_a),
        .redundant_cnt (cnt_a)
    );

    sr_cmd_driver #(
        .PULSE_CYCLES   (3),
        .GAP_CYCLES     (2),
        .SKIP_REDUNDANT (1'b1),
        .CNT_W          (8)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .req_valid     (valid_b),
        .req_ready     (ready_b),
        .req_op        (op_b),
        .s             (s_b),
        .r             (r_b),
        .q_shadow      (qs_b),
        .busy          (busy_b),
        .redundant_cnt (cnt_b)
    );

    // Downstream SR flops sampling on negedge, sharing the driver's reset.
    always @(negedge clk or posedge rst_a) begin
        if (rst_a)    qm_a <= 1'b0;
        else if (s_a) qm_a <= 1'b1;
        else if (r_a) qm_a <= 1'b0;
    end

    always @(negedge clk or posedge rst_b) begin
        if (rst_b)    qm_b <= 1'b0;
        else if (s_b) qm_b <= 1'b1;
        else if (r_b) qm_b <= 1'b0;
    end

    always @(negedge clk) begin
        if ((s_a & r_a) | (s_b & r_b)) sr_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        op_a = 2'b00; op_b = 2'b00;
        #1;
        chk("rst_ready_a", ready_a, 0);
        chk("rst_s_a", s_a, 0);
        chk("rst_r_a", r_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        step();
        chk("rel_ready_a", ready_a, 1);
        chk("rel_s_a", s_a, 0);
        chk("rel_r_a", r_a, 0);
        chk("rel_qs_a", qs_a, 0);
        chk("rel_cnt_a", cnt_a, 0);
        chk("rel_busy_a", busy_a, 0);
        chk("rel_ready_b", ready_b, 1);

        // op ignored without valid
        op_a = 2'b10;
        step();
        chk("novalid_s_a", s_a, 0);
        chk("novalid_busy_a", busy_a, 0);

        // SET with defaults
        valid_a = 1'b1; op_a = 2'b10;
        step();
        valid_a = 1'b0;
        chk("set_s", s_a, 1);
        chk("set_r", r_a, 0);
        chk("set_busy", busy_a, 1);
        chk("set_ready", ready_a, 0);
        chk("set_qs_early", qs_a, 0);
        step();
        chk("set_s_off", s_a, 0);
        chk("set_qs", qs_a, 1);
        chk("set_gap_ready", ready_a, 0);
        chk("set_gap_busy", busy_a, 1);
        @(negedge clk); #1;
        chk("set_flop_q", qm_a, 1);
        step();
        chk("set_ready_back", ready_a, 1);
        chk("set_busy_off", busy_a, 0);

        // redundant SET then CLR, back to back
        valid_a = 1'b1; op_a = 2'b10;
        step();
        chk("redset_s", s_a, 0);
        chk("redset_cnt", cnt_a, 1);
        chk("redset_ready", ready_a, 1);
        op_a = 2'b01;
        step();
        valid_a = 1'b0;
        chk("clr_r", r_a, 1);
        chk("clr_s", s_a, 0);
        step();
        chk("clr_r_off", r_a, 0);
        chk("clr_qs", qs_a, 0);
        step();
        chk("clr_ready_back", ready_a, 1);
        @(negedge clk); #1;
        chk("clr_flop_q", qm_a, 0);

        // counter saturation
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("sat_rst_cnt", cnt_a, 0);
        chk("sat_rst_ready", ready_a, 0);
        @(negedge clk);
        rst_a = 1'b0;
        valid_a = 1'b1; op_a = 2'b01;
        repeat (254) step();
        chk("sat_cnt_254", cnt_a, 254);
        step();
        chk("sat_cnt_255", cnt_a, 255);
        repeat (45) step();
        chk("sat_cnt_hold", cnt_a, 255);
        chk("sat_r", r_a, 0);
        chk("sat_busy", busy_a, 0);
        valid_a = 1'b0;

        // reset during the 2nd PULSE cycle (instance b)
        valid_b = 1'b1; op_b = 2'b10;
        step();
        valid_b = 1'b0;
        chk("b_set_s1", s_b, 1);
        step();
        chk("b_set_s2", s_b, 1);
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_rst_s", s_b, 0);
        chk("b_rst_qs", qs_b, 0);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_ready", ready_b, 0);
        chk("b_rst_flop_q", qm_b, 0);
        @(negedge clk);
        rst_b = 1'b0;
        step();
        chk("b_rel_ready", ready_b, 1);
        valid_b = 1'b1; op_b = 2'b01;
        step();
        valid_b = 1'b0;
        chk("b_clr_cnt", cnt_b, 1);
        chk("b_clr_r", r_b, 0);
        chk("b_clr_busy", busy_b, 0);

        // TGL from 0 with PULSE=3, GAP=2
        valid_b = 1'b1; op_b = 2'b11;
        step();
        valid_b = 1'b0;
        chk("tgl_s_c1", s_b, 1);
        chk("tgl_r_c1", r_b, 0);
        chk("tgl_busy", busy_b, 1);
        step();
        chk("tgl_s_c2", s_b, 1);
        step();
        chk("tgl_s_c3", s_b, 1);
        chk("tgl_qs_pending", qs_b, 0);
        step();
        chk("tgl_s_off", s_b, 0);
        chk("tgl_qs", qs_b, 1);
        chk("tgl_gap1_ready", ready_b, 0);
        step();
        chk("tgl_gap2_ready", ready_b, 0);
        chk("tgl_gap2_s", s_b, 0);
        step();
        chk("tgl_ready_back", ready_b, 1);
        chk("tgl_busy_off", busy_b, 0);
        chk("tgl_flop_q", qm_b, 1);

        chk("s_and_r_never", sr_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
- Command-side driver for the team's negedge-sampled SR flip-flop: accepts level commands over a valid/ready handshake and converts them into clean, timed s/r pulses.
- Never drives s=r=1. Enforces a minimum pulse width and an inter-command 00 gap.
- Tracks a shadow copy of the downstream q so toggle and redundant-command filtering are possible without reading q back.
- Sits between control logic and any SR storage element; updates on posedge clk so s/r are stable at the sampling negedge.

Parameters:
- PULSE_CYCLES, 1, clock cycles s or r is held high per command (must be >= 1).
- GAP_CYCLES, 1, cycles of s=r=0 forced after each pulse before the next accept (0 allowed).
- SKIP_REDUNDANT, 1, 1 = commands whose target equals q_shadow produce no pulse.
- CNT_W, 8, width of the redundant-command counter.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, reset, asynchronous, active-high.
- req_valid, input, 1, command valid.
- req_ready, output, 1, driver can accept a command this cycle.
- req_op, input, 2, 00 hold, 01 clear, 10 set, 11 toggle.
- s, output, 1, set drive to SR element (registered).
- r, output, 1, reset drive to SR element (registered).
- q_shadow, output, 1, driver's model of downstream q.
- busy, output, 1, high in PULSE or GAP.
- redundant_cnt, output, CNT_W, saturating count of filtered non-hold commands.

Behaviour:
- Reset (async, immediate):
  - s=0, r=0, q_shadow=0, redundant_cnt=0, state=IDLE, busy=0.
  - req_ready reads 0 while rst is high and 1 from the first cycle after deassertion.
- States: IDLE, PULSE, GAP. req_ready = (state==IDLE) && !rst. busy = !IDLE.
- Accept on posedge when req_valid && req_ready. Target computed from q_shadow at that edge:
  - 00 → q_shadow
  - 01 → 0
  - 10 → 1
  - 11 → ~q_shadow
- No-pulse case: op==00, or (SKIP_REDUNDANT && target==q_shadow).
  - Stay in IDLE; s and r stay 0.
  - If op!=00, redundant_cnt += 1, saturating at all-ones.
  - Back-to-back accepts are allowed.
- Pulse case:
  - At the accept edge, go to PULSE with s=target, r=~target, and load the timer with PULSE_CYCLES-1.
- PULSE:
  - s/r held for exactly PULSE_CYCLES posedges.
  - On the last edge: s=r=0, q_shadow<=target.
  - Next state is GAP, loading GAP_CYCLES-1, or IDLE if GAP_CYCLES==0.
- GAP: s=r=0 for GAP_CYCLES cycles, then IDLE.
- Latency (accept at edge N):
  - s/r high over [N, N+PULSE_CYCLES).
  - q_shadow updates at edge N+PULSE_CYCLES.
  - req_ready returns after edge N+PULSE_CYCLES+GAP_CYCLES.
- Invariant: s&r==0 every cycle, including during reset.
- req_op is ignored when req_valid is low or req_ready is low; no queueing.
- Reset mid-PULSE/GAP: outputs drop to 0 immediately and q_shadow=0. This matches the SR flop, which shares rst.
- toggle uses the committed q_shadow only; in-flight targets are never visible because accept is blocked until IDLE.
- PULSE_CYCLES==0 is a configuration error; flag it with an elaboration-time check.

Decomposition:
- Shared package holds:
  - op encodings OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11
  - state encoding IDLE/PULSE/GAP
- One natural sub-module, sr_pulse_timer: loadable down-counter with a done flag, used for both the PULSE and GAP phases.

Test Plan:
- Reset release → after rst 1→0: req_ready=1, s=r=0, q_shadow=0, redundant_cnt=0.
- Defaults, SET accepted at edge N → s=1, r=0 for 1 cycle; q_shadow=1 at edge N+1; ready=0 during GAP; ready=1 after edge N+2. Downstream SR flop q=1 at the following negedge.
- q_shadow=1, SET then CLR back-to-back:
  - SET filtered, redundant_cnt=1, no pulse.
  - CLR pulses r=1 for 1 cycle; q_shadow=0.
- PULSE_CYCLES=3, GAP_CYCLES=2, TGL from q_shadow=0 → s high exactly 3 cycles, 2 gap cycles, ready returns 5 cycles after accept, q_shadow=1.
- rst pulsed high during the 2nd PULSE cycle of a SET → s falls immediately, q_shadow=0; after release a new CLR is filtered (cnt=1).
- 300 redundant CLRs from q_shadow=0 with CNT_W=8 → redundant_cnt saturates at 255; an assertion confirms s&r never 1 throughout.
